svm_stream_adapter: RTL



---
 rtl/svm_stream_adapter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/svm_stream_adapter.sv
// Streaming wrapper around a flat combinational SVM classifier core.
// Features arrive one per handshake and are packed into the classifier input word.
// After a fixed settling time the class index and vote vector are captured
// and offered on a result stream, tagged with a running sample number.
module svm_stream_adapter #(
  parameter int NUM_FEAT = 4,
  parameter int FEAT_W   = 4,
  parameter int CLS_W    = 2,
  parameter int PREDO_W  = 6,
  parameter int EVAL_CYC = 1,
  parameter int IDX_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FEAT_W-1:0]          s_feat,
  input  logic                       s_last,
  output logic [NUM_FEAT*FEAT_W-1:0] cls_inp,
  input  logic [CLS_W-1:0]           cls_out,
  input  logic [PREDO_W-1:0]         cls_predo,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CLS_W-1:0]           m_class,
  output logic [PREDO_W-1:0]         m_votes,
  output logic [IDX_W-1:0]           m_index,
  output logic                       m_frame_err
);

  localparam int KW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int CW = 4;
  localparam logic [KW-1:0] LAST_K    = KW'(NUM_FEAT - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(EVAL_CYC - 1);

  typedef enum logic [1:0] {
    COLLECT,
    EVAL,
    RESULT
  } state_e;

  state_e                       state_q, state_d;
  logic [KW-1:0]                featIdx_q, featIdx_d;
  logic [CW-1:0]                waitCnt_q, waitCnt_d;
  logic                         frameErr_q, frameErr_d;
  logic [IDX_W-1:0]             sampleCnt_q, sampleCnt_d;
  logic [NUM_FEAT*FEAT_W-1:0]   featInp_q, featInp_d;
  logic [CLS_W-1:0]             resClass_q, resClass_d;
  logic [PREDO_W-1:0]           resVotes_q, resVotes_d;
  logic [IDX_W-1:0]             resIndex_q, resIndex_d;
  logic                         resErr_q, resErr_d;

  assign cls_inp     = featInp_q;
  assign m_class     = resClass_q;
  assign m_votes     = resVotes_q;
  assign m_index     = resIndex_q;
  assign m_frame_err = resErr_q;

  // Next-state logic: pack features, wait for the classifier to settle, then hold the result until taken.
  always_comb begin
    state_d     = state_q;
    featIdx_d   = featIdx_q;
    waitCnt_d   = waitCnt_q;
    frameErr_d  = frameErr_q;
    sampleCnt_d = sampleCnt_q;
    featInp_d   = featInp_q;
    resClass_d  = resClass_q;
    resVotes_d  = resVotes_q;
    resIndex_d  = resIndex_q;
    resErr_d    = resErr_q;
    s_ready     = 1'b0;
    m_valid     = 1'b0;

    case (state_q)
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (featIdx_q == '0) begin
            featInp_d = '0;
          end
          featInp_d[int'(featIdx_q)*FEAT_W +: FEAT_W] = s_feat;
          if (featIdx_q == LAST_K) begin
            frameErr_d = ~s_last;
            featIdx_d  = '0;
            waitCnt_d  = '0;
            state_d    = EVAL;
          end else if (s_last) begin
            frameErr_d = 1'b1;
            featIdx_d  = '0;
            waitCnt_d  = '0;
            state_d    = EVAL;
          end else begin
            featIdx_d = featIdx_q + 1'b1;
          end
        end
      end

      EVAL: begin
        if (waitCnt_q == WAIT_LAST) begin
          resClass_d  = cls_out;
          resVotes_d  = cls_predo;
          resIndex_d  = sampleCnt_q;
          resErr_d    = frameErr_q;
          sampleCnt_d = sampleCnt_q + 1'b1;
          frameErr_d  = 1'b0;
          state_d     = RESULT;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end

      RESULT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          featIdx_d = '0;
          state_d   = COLLECT;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial sample or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      featIdx_q   <= '0;
      waitCnt_q   <= '0;
      frameErr_q  <= 1'b0;
      sampleCnt_q <= '0;
      featInp_q   <= '0;
      resClass_q  <= '0;
      resVotes_q  <= '0;
      resIndex_q  <= '0;
      resErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      featIdx_q   <= featIdx_d;
      waitCnt_q   <= waitCnt_d;
      frameErr_q  <= frameErr_d;
      sampleCnt_q <= sampleCnt_d;
      featInp_q   <= featInp_d;
      resClass_q  <= resClass_d;
      resVotes_q  <= resVotes_d;
      resIndex_q  <= resIndex_d;
      resErr_q    <= resErr_d;
    end
  end

endmodule
